// File: rtl/rv32i_pipe_ctrl_if.sv
// Control bundle between the RV32I pipeline datapath and its hazard/sequencing controller.
// The master side is the datapath; the slave side is rv32i_pipe_ctrl.
interface rv32i_pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      id_iw;
    logic [31:0]      ex_iw;
    logic             jump_taken;
    logic             mem_busy;
    logic             resume;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             freeze;
    logic             halted;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] load_stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_iw, ex_iw, jump_taken, mem_busy, resume,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze, halted,
        input  state_out, load_stall_cnt, flush_cnt
    );

    modport slave (
        input  id_iw, ex_iw, jump_taken, mem_busy, resume,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze, halted,
        output state_out, load_stall_cnt, flush_cnt
    );
endinterface

// File: rtl/rv32i_pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline (load-use bubble, jump flush,
// memory freeze, EBREAK park). Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module rv32i_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic          clk,
    input  logic          reset,
    rv32i_pipe_ctrl_if.slave bus
);
    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_LSTALL = 3'd1;
    localparam logic [2:0] ST_FLUSH  = 3'd2;
    localparam logic [2:0] ST_HALT   = 3'd3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

    logic [6:0] id_op_s;
    logic [6:0] ex_op_s;
    logic [4:0] ex_rd_s;
    logic       ex_load_s;
    logic       uses_rs1_s;
    logic       uses_rs2_s;
    logic       load_use_s;
    logic       ebreak_s;

    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic [2:0] flush_left_r;
    logic [2:0] flush_left_next_s;

    logic pc_hold_s;
    logic ifid_hold_s;
    logic ifid_flush_s;
    logic idex_bubble_s;
    logic freeze_s;
    logic halted_s;

    assign id_op_s = bus.id_iw[6:0];
    assign ex_op_s = bus.ex_iw[6:0];
    assign ex_rd_s = bus.ex_iw[11:7];

    assign ex_load_s  = (ex_op_s == OP_LOAD) && (ex_rd_s != 5'd0);
    assign uses_rs1_s = !((id_op_s == OP_LUI) || (id_op_s == OP_AUIPC) || (id_op_s == OP_JAL));
    assign uses_rs2_s = (id_op_s == OP_BRANCH) || (id_op_s == OP_STORE) || (id_op_s == OP_OP);
    assign load_use_s = ex_load_s &&
                        ((uses_rs1_s && (bus.id_iw[19:15] == ex_rd_s)) ||
                         (uses_rs2_s && (bus.id_iw[24:20] == ex_rd_s)));
    assign ebreak_s   = (bus.id_iw == EBREAK_IW);

    // Mealy control decode and next-state selection; priority reset > mem_busy > state actions
    always_comb begin
        pc_hold_s         = 1'b0;
        ifid_hold_s       = 1'b0;
        ifid_flush_s      = 1'b0;
        idex_bubble_s     = 1'b0;
        freeze_s          = 1'b0;
        halted_s          = 1'b0;
        state_next_s      = state_r;
        flush_left_next_s = flush_left_r;
        if (reset) begin
            state_next_s      = ST_RUN;
            flush_left_next_s = 3'd0;
        end else if (bus.mem_busy) begin
            freeze_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN, ST_LSTALL: begin
                    // In LSTALL the bubble sits in EX, so the old load no longer creates a hazard
                    if (load_use_s && (state_r == ST_RUN)) begin
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_next_s  = ST_LSTALL;
                    end else if (ebreak_s) begin
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_next_s  = ST_HALT;
                    end else if (bus.jump_taken) begin
                        ifid_flush_s      = 1'b1;
                        flush_left_next_s = FLUSH_LOAD;
                        state_next_s      = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    ifid_flush_s = 1'b1;
                    if (flush_left_r <= 3'd1) begin
                        flush_left_next_s = 3'd0;
                        state_next_s      = ST_RUN;
                    end else begin
                        flush_left_next_s = flush_left_r - 3'd1;
                        state_next_s      = ST_FLUSH;
                    end
                end
                ST_HALT: begin
                    if (bus.resume) begin
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_next_s  = ST_RUN;
                    end else begin
                        halted_s      = 1'b1;
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_next_s  = ST_HALT;
                    end
                end
                default: begin
                    state_next_s      = ST_RUN;
                    flush_left_next_s = 3'd0;
                end
            endcase
        end
    end

    // State and remaining-flush registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_RUN;
            flush_left_r <= 3'd0;
        end else begin
            state_r      <= state_next_s;
            flush_left_r <= flush_left_next_s;
        end
    end

    assign bus.pc_hold     = pc_hold_s;
    assign bus.ifid_hold   = ifid_hold_s;
    assign bus.ifid_flush  = ifid_flush_s;
    assign bus.idex_bubble = idex_bubble_s;
    assign bus.freeze      = freeze_s;
    assign bus.halted      = halted_s;
    assign bus.state_out   = reset ? 3'd0 : state_r;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             stall_evt_s;

    assign stall_evt_s = (state_r == ST_RUN) && !bus.mem_busy && load_use_s;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.load_stall_cnt = reset ? {CNT_W{1'b0}} : stall_cnt_r;
    assign bus.flush_cnt      = reset ? {CNT_W{1'b0}} : flush_cnt_r;
`else
    assign bus.load_stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl: three instances (FLUSH_CYCLES 1/2/3, CNT_W 32/32/4) share stimulus.
module tb_rv32i_pipe_ctrl;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] LW_X5     = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] LW_X0     = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD_X5    = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] ADD_X0    = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] SW_X5     = 32'h0051_2023; // sw   x5,0(x2)  (x5 via rs2)
    localparam logic [31:0] ADDI_IMM5 = 32'h0053_8313; // addi x6,x7,5   (rs2 field = 5, unused)
    localparam logic [31:0] LUI_F5    = 32'h0002_82B7; // lui  x5,0x28   (rs1 field = 5, unused)
    localparam logic [31:0] JAL_F5    = 32'h0002_80EF; // jal  x1,...    (rs1 field = 5, unused)
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rv32i_pipe_ctrl_if #(.CNT_W(32)) if1 ();
    rv32i_pipe_ctrl_if #(.CNT_W(32)) if2 ();
    rv32i_pipe_ctrl_if #(.CNT_W(4))  if3 ();

    rv32i_pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    rv32i_pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
    rv32i_pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4))  u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze, halted}
    function automatic logic [5:0] ctl1();
        return {if1.pc_hold, if1.ifid_hold, if1.ifid_flush, if1.idex_bubble, if1.freeze, if1.halted};
    endfunction
    function automatic logic [5:0] ctl2();
        return {if2.pc_hold, if2.ifid_hold, if2.ifid_flush, if2.idex_bubble, if2.freeze, if2.halted};
    endfunction
    function automatic logic [5:0] ctl3();
        return {if3.pc_hold, if3.ifid_hold, if3.ifid_flush, if3.idex_bubble, if3.freeze, if3.halted};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] id, input logic [31:0] ex, input logic jt,
                          input logic mb, input logic rs);
        if1.id_iw = id; if1.ex_iw = ex; if1.jump_taken = jt; if1.mem_busy = mb; if1.resume = rs;
        if2.id_iw = id; if2.ex_iw = ex; if2.jump_taken = jt; if2.mem_busy = mb; if2.resume = rs;
        if3.id_iw = id; if3.ex_iw = ex; if3.jump_taken = jt; if3.mem_busy = mb; if3.resume = rs;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (ctl1() !== 6'b000000 || ctl3() !== 6'b000000) begin
            errors++; $display("FAIL reset_ctl: got %b/%b expected 000000", ctl1(), ctl3());
        end
        checks++;
        if (if1.state_out !== 3'd0 || if1.load_stall_cnt !== 32'd0 || if3.flush_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_state: got st=%0d lsc=%0d fc=%0d expected 0", if1.state_out, if1.load_stall_cnt, if3.flush_cnt);
        end
        reset = 1'b0;
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL post_reset_idle: got %b st=%0d expected 000000 st=0", ctl1(), if1.state_out);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0); // jump in the stall cycle must be ignored
        #1;
        checks++;
        if (ctl1() !== 6'b110100 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL lu_rs1_stall: got %b st=%0d expected 110100 st=0", ctl1(), if1.state_out);
        end
        tick();
        set_in(ADD_X5, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000 || if1.state_out !== 3'd1) begin
            errors++; $display("FAIL lu_lstall: got %b st=%0d expected 000000 st=1", ctl1(), if1.state_out);
        end
        tick();
        checks++;
        if (if1.state_out !== 3'd0 || if1.load_stall_cnt !== (PERF ? 32'd1 : 32'd0) || if1.flush_cnt !== 32'd0) begin
            errors++; $display("FAIL lu_cnt1: got st=%0d lsc=%0d fc=%0d expected st=0 lsc=%0d fc=0", if1.state_out, if1.load_stall_cnt, if1.flush_cnt, PERF ? 1 : 0);
        end
        set_in(SW_X5, LW_X5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b110100) begin
            errors++; $display("FAIL lu_rs2_stall: got %b expected 110100", ctl1());
        end
        tick();
        set_in(SW_X5, LW_X5, 1'b1, 1'b0, 1'b0); // load still in EX is suppressed; jump taken
        #1;
        checks++;
        if (ctl1() !== 6'b001000 || if1.state_out !== 3'd1) begin
            errors++; $display("FAIL lstall_jump: got %b st=%0d expected 001000 st=1", ctl1(), if1.state_out);
        end
        tick();
        set_in(ADDI_IMM5, LW_X5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL lu_unused_rs2: got %b st=%0d expected 000000 st=0", ctl1(), if1.state_out);
        end
        tick();
        checks++;
        if (if1.load_stall_cnt !== (PERF ? 32'd2 : 32'd0) || if1.flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            errors++; $display("FAIL lu_cnt2: got lsc=%0d fc=%0d expected lsc=%0d fc=%0d", if1.load_stall_cnt, if1.flush_cnt, PERF ? 2 : 0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_in(ADD_X0, LW_X0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000) begin
            errors++; $display("FAIL nohaz_x0: got %b expected 000000", ctl1());
        end
        tick();
        set_in(LUI_F5, LW_X5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000) begin
            errors++; $display("FAIL nohaz_lui: got %b expected 000000", ctl1());
        end
        tick();
        set_in(JAL_F5, LW_X5, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL nohaz_jal: got %b st=%0d expected 000000 st=0", ctl1(), if1.state_out);
        end
        tick();
    endtask

    task automatic test_jump();
        do_reset();
        set_in(NOP, NOP, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl2() !== 6'b001000 || if2.state_out !== 3'd0) begin
            errors++; $display("FAIL jump_c1: got %b st=%0d expected 001000 st=0", ctl2(), if2.state_out);
        end
        tick();
        set_in(ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0); // ignored while flushing
        #1;
        checks++;
        if (ctl2() !== 6'b001000 || if2.state_out !== 3'd2) begin
            errors++; $display("FAIL jump_c2: got %b st=%0d expected 001000 st=2", ctl2(), if2.state_out);
        end
        checks++;
        if (ctl1() !== 6'b110100 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL jump_fc1_run: got %b st=%0d expected 110100 st=0", ctl1(), if1.state_out);
        end
        tick();
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl2() !== 6'b000000 || if2.state_out !== 3'd0) begin
            errors++; $display("FAIL jump_c3: got %b st=%0d expected 000000 st=0", ctl2(), if2.state_out);
        end
        checks++;
        if (if2.flush_cnt !== (PERF ? 32'd2 : 32'd0) || if2.load_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL jump_cnt: got fc=%0d lsc=%0d expected fc=%0d lsc=0", if2.flush_cnt, if2.load_stall_cnt, PERF ? 2 : 0);
        end
        tick();
    endtask

    task automatic test_ebreak();
        do_reset();
        set_in(EBREAK, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b110100 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL ebreak_detect: got %b st=%0d expected 110100 st=0", ctl1(), if1.state_out);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(EBREAK, i[0] ? LW_X5 : NOP, i[0], 1'b0, 1'b0);
            #1;
            checks++;
            if (ctl1() !== 6'b110101 || if1.state_out !== 3'd3) begin
                errors++; $display("FAIL halt_hold%0d: got %b st=%0d expected 110101 st=3", i, ctl1(), if1.state_out);
            end
            tick();
        end
        set_in(EBREAK, NOP, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if ({if1.pc_hold, if1.ifid_hold, if1.ifid_flush, if1.freeze, if1.halted} !== 5'b00100) begin
            errors++; $display("FAIL resume_cycle: got %b expected 00100", {if1.pc_hold, if1.ifid_hold, if1.ifid_flush, if1.freeze, if1.halted});
        end
        tick();
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b000000 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL after_resume: got %b st=%0d expected 000000 st=0", ctl1(), if1.state_out);
        end
        tick();
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl1() !== 6'b000000) begin
            errors++; $display("FAIL resume_in_run: got %b expected 000000", ctl1());
        end
        tick();
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (if1.state_out !== 3'd0) begin
            errors++; $display("FAIL resume_in_run_st: got %0d expected 0", if1.state_out);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        set_in(NOP, NOP, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl3() !== 6'b001000 || if3.state_out !== 3'd2) begin
            errors++; $display("FAIL frz_flush1: got %b st=%0d expected 001000 st=2", ctl3(), if3.state_out);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(ADD_X5, LW_X5, 1'b1, 1'b1, 1'b0);
            #1;
            checks++;
            if (ctl3() !== 6'b000010 || if3.state_out !== 3'd2 || ctl1() !== 6'b000010) begin
                errors++; $display("FAIL frz_hold%0d: got %b/%b st=%0d expected 000010/000010 st=2", i, ctl3(), ctl1(), if3.state_out);
            end
            tick();
        end
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl3() !== 6'b001000 || if3.state_out !== 3'd2 || ctl1() !== 6'b000000) begin
            errors++; $display("FAIL frz_resume: got %b/%b st=%0d expected 001000/000000 st=2", ctl3(), ctl1(), if3.state_out);
        end
        tick();
        #1;
        checks++;
        if (ctl3() !== 6'b000000 || if3.state_out !== 3'd0 || if3.flush_cnt !== (PERF ? 4'd3 : 4'd0)) begin
            errors++; $display("FAIL frz_done: got %b st=%0d fc=%0d expected 000000 st=0 fc=%0d", ctl3(), if3.state_out, if3.flush_cnt, PERF ? 3 : 0);
        end
        tick();
    endtask

    task automatic test_reset_abort_and_wrap();
        do_reset();
        set_in(EBREAK, NOP, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        checks++;
        if (if1.state_out !== 3'd3 || if1.halted !== 1'b1) begin
            errors++; $display("FAIL pre_reset_halt: got st=%0d halted=%b expected st=3 halted=1", if1.state_out, if1.halted);
        end
        reset = 1'b1;
        set_in(EBREAK, LW_X5, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (ctl1() !== 6'b000000 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL reset_in_halt: got %b st=%0d expected 000000 st=0", ctl1(), if1.state_out);
        end
        tick();
        reset = 1'b0;
        set_in(NOP, NOP, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl1() !== 6'b001000 || if1.state_out !== 3'd0) begin
            errors++; $display("FAIL after_halt_reset: got %b st=%0d expected 001000 st=0", ctl1(), if1.state_out);
        end
        tick();
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (ctl3() !== 6'b000000 || if3.state_out !== 3'd0) begin
            errors++; $display("FAIL reset_in_flush: got %b st=%0d expected 000000 st=0", ctl3(), if3.state_out);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl3() !== 6'b000000 || if3.state_out !== 3'd0) begin
            errors++; $display("FAIL after_flush_reset: got %b st=%0d expected 000000 st=0", ctl3(), if3.state_out);
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0);
            tick();
            set_in(ADD_X5, NOP, 1'b0, 1'b0, 1'b0);
            tick();
            if (i == 14) begin
                checks++;
                if (if3.load_stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin
                    errors++; $display("FAIL cnt_max: got %0d expected %0d", if3.load_stall_cnt, PERF ? 15 : 0);
                end
            end
        end
        checks++;
        if (if3.load_stall_cnt !== 4'd0 || if1.load_stall_cnt !== (PERF ? 32'd16 : 32'd0)) begin
            errors++; $display("FAIL cnt_wrap: got w4=%0d w32=%0d expected w4=0 w32=%0d", if3.load_stall_cnt, if1.load_stall_cnt, PERF ? 16 : 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_in(NOP, NOP, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_jump();
        test_ebreak();
        test_freeze();
        test_reset_abort_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rv32i_pipe_ctrl.md
Name: rv32i_pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards that forwarding into the decode stage cannot cover, and inserts exactly one bubble.
- Flushes the IF/ID register after a jump or branch taken in decode.
- Freezes the whole pipeline while data memory is busy.
- Parks the core on EBREAK until an external resume pulse arrives.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive IF/ID flush cycles after a taken jump (1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- id_iw  in  32  instruction word currently in decode
- ex_iw  in  32  instruction word currently in execute
- jump_taken  in  1  jump/branch resolved taken in decode this cycle
- mem_busy  in  1  data memory not ready; pipeline must freeze
- resume  in  1  single-cycle pulse releasing HALT
- pc_hold  out  1  hold PC
- ifid_hold  out  1  hold IF/ID register
- ifid_flush  out  1  load NOP (32'h13) into IF/ID
- idex_bubble  out  1  load NOP (32'h13) into ID/EX; wb enable forced 0
- freeze  out  1  all pipeline registers hold
- halted  out  1  core parked on EBREAK
- state_out  out  3  current FSM state encoding
- load_stall_cnt  out  CNT_W  count of load-use bubbles inserted
- flush_cnt  out  CNT_W  count of flush cycles asserted

Behaviour:
Decode rules
- ex_load = (ex_iw[6:0]==7'b0000011) and ex_iw[11:7]!=0.
- ID uses rs1 unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
- ID uses rs2 only for opcodes 1100011, 0100011, 0110011.
- load_use = ex_load and ((uses_rs1 and id_iw[19:15]==ex_iw[11:7]) or (uses_rs2 and id_iw[24:20]==ex_iw[11:7])).
- ebreak = (id_iw==32'h00100073).

Output timing
- FSM state is registered; control outputs are combinational from state and current inputs (Mealy), so a hazard acts in the cycle it is seen.

States (encodings)
- RUN=0, LSTALL=1, FLUSH=2, HALT=3. MEM_WAIT is not a state: it is an overlay on any state.

Reset
- State goes to RUN; counters and flush counter clear to 0.
- While reset=1, every output is 0 and state_out=0.
- Reset mid-HALT or mid-FLUSH aborts immediately to RUN.

Priority in any state: reset > mem_busy > HALT > load_use > ebreak > jump_taken.

mem_busy=1
- freeze=1; all other control outputs 0.
- State, flush counter and perf counters hold.
- Events seen during freeze are ignored; they are re-evaluated once freeze deasserts.

RUN
- load_use: pc_hold=ifid_hold=idex_bubble=1; load_stall_cnt+1; next state LSTALL.
  - jump_taken in the same cycle is ignored, because the branch operands are not yet valid.
- else ebreak: pc_hold=ifid_hold=idex_bubble=1; next state HALT.
- else jump_taken: ifid_flush=1; flush_cnt+1; internal counter loads FLUSH_CYCLES-1.
  - If FLUSH_CYCLES==1, stay in RUN; otherwise go to FLUSH.
- else all outputs 0.

LSTALL
- Lasts exactly one cycle; all outputs 0; returns to RUN.
- load_use detection is suppressed (EX holds the bubble).
- jump_taken is handled exactly as in RUN.

FLUSH
- ifid_flush=1 and flush_cnt+1 every cycle; counter decrements.
- Returns to RUN when the counter reaches 0.
- load_use and jump_taken are ignored (ID holds a NOP).

HALT
- halted=1; pc_hold=ifid_hold=idex_bubble=1.
- On resume: one cycle with ifid_flush=1, pc_hold=0, halted=0 (the EBREAK is discarded); next state RUN.
- resume outside HALT is ignored.

Counters
- Unsigned, wrap from 2^CNT_W-1 to 0.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: load_stall_cnt and flush_cnt are implemented as described above.
- Undefined: no counter registers exist; both outputs are tied to 0; all control behaviour is identical.

Test Plan:
1. Load-use: ex_iw=LW x5,0(x1) (32'h0000A283), id_iw=ADD x6,x5,x2 (32'h00228333) -> one cycle with pc_hold=ifid_hold=idex_bubble=1; next cycle all 0; load_stall_cnt=1.
2. No hazard from x0 or LUI: ex_iw=LW x0,0(x1) with ID reading x0, then ex_iw=LW x5 with id_iw=LUI x5 -> no stall outputs in either case.
3. Jump: jump_taken=1, FLUSH_CYCLES=2 -> ifid_flush=1 for exactly 2 cycles; flush_cnt=2; state_out sequence 0,2,0.
4. EBREAK: id_iw=32'h00100073 -> halted=1 and holds asserted for 10 idle cycles; resume pulse -> one ifid_flush cycle, then RUN with halted=0.
5. Freeze: mem_busy=1 for 3 cycles during FLUSH (FLUSH_CYCLES=3) -> freeze=1, ifid_flush=0, remaining flush count preserved; flush completes after mem_busy drops.
6. Reset mid-HALT, plus counter wrap with CNT_W=4 after 16 stalls -> outputs 0 and state RUN after reset; load_stall_cnt reads 0 after 16 stalls.
